// File: rtl/p_hardisc.sv
// Shared types and helpers for the EX-stage sequential divider.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package p_hardisc;

    localparam int XLEN  = 32;
    localparam int CNT_W = 5;

    // Divide function encoding carried on the OPEX bus
    typedef enum logic [1:0] {
        DIVF_DIV  = 2'b00,
        DIVF_DIVU = 2'b01,
        DIVF_REM  = 2'b10,
        DIVF_REMU = 2'b11
    } div_func;

    // Divider control states, kept as plain constants for older tools
    typedef logic [1:0] div_state;
    localparam div_state DS_IDLE = 2'd0;
    localparam div_state DS_BUSY = 2'd1;
    localparam div_state DS_DONE = 2'd2;

    function automatic logic is_signed_f(input div_func f);
        return (f == DIVF_DIV) || (f == DIVF_REM);
    endfunction

    function automatic logic is_rem_f(input div_func f);
        return (f == DIVF_REM) || (f == DIVF_REMU);
    endfunction

endpackage

// File: rtl/divider_step.sv
// One restoring-division iteration: shift {rem,quo} left, trial subtract, set quotient bit.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to register the result.
module divider_step
    import p_hardisc::*;
(
    input  logic [XLEN-1:0] rem,
    input  logic [XLEN-1:0] quo,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_nxt,
    output logic [XLEN-1:0] quo_nxt
);

    // The shifted partial remainder needs one extra bit: rem < divisor before the shift
    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    assign shifted = {rem, quo[XLEN-1]};
    assign diff    = shifted - {1'b0, divisor};

    // Borrow out of the trial subtract means the divisor did not fit: restore
    assign rem_nxt = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
    assign quo_nxt = {quo[XLEN-2:0], ~diff[XLEN]};

endmodule

// File: rtl/ex_divider_seq.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU; optional DIVIDER_EARLY_EXIT_EN macro.
// Latency: done 33 cycles after accept (1 cycle for div-by-zero/overflow when DIVIDER_EARLY_EXIT_EN).
// Backpressure: busy stalls the OP stage while iterating; hold freezes the result in DONE; flush aborts.
module ex_divider_seq
    import p_hardisc::*;
(
    input  logic            s_clk_i,
    input  logic            s_resetn_i,
    input  logic            s_start_i,
    input  logic [1:0]      s_func_i,
    input  logic [XLEN-1:0] s_op1_i,
    input  logic [XLEN-1:0] s_op2_i,
    input  logic            s_flush_i,
    input  logic            s_hold_i,
    output logic            s_busy_o,
    output logic            s_done_o,
    output logic [XLEN-1:0] s_result_o
);

    div_state         state;
    logic [CNT_W-1:0] cnt;
    div_func          func_q;
    logic [XLEN-1:0]  rem_q;
    logic [XLEN-1:0]  quo_q;
    logic [XLEN-1:0]  dvs_q;
    logic             sign_q;
    logic             sign_r;
    logic             dz_q;

    logic [XLEN-1:0]  rem_nxt;
    logic [XLEN-1:0]  quo_nxt;
    logic             in_signed;
    logic             accept;
    logic             dz_in;
    logic             early;
    logic [XLEN-1:0]  op1_abs;
    logic [XLEN-1:0]  op2_abs;
    logic [XLEN-1:0]  res;

    assign in_signed = is_signed_f(div_func'(s_func_i));
    assign accept    = (state == DS_IDLE) && s_start_i && !s_flush_i;
    assign dz_in     = (s_op2_i == '0);
    assign op1_abs   = (in_signed && s_op1_i[XLEN-1]) ? -s_op1_i : s_op1_i;
    assign op2_abs   = (in_signed && s_op2_i[XLEN-1]) ? -s_op2_i : s_op2_i;

`ifdef DIVIDER_EARLY_EXIT_EN
    // Results of these two cases are known at accept, so skip the iteration
    logic ovf_in;
    assign ovf_in = in_signed && (s_op1_i == {1'b1, {(XLEN-1){1'b0}}}) && (s_op2_i == '1);
    assign early  = dz_in || ovf_in;
`else
    assign early  = 1'b0;
`endif

    divider_step u_step (
        .rem     (rem_q),
        .quo     (quo_q),
        .divisor (dvs_q),
        .rem_nxt (rem_nxt),
        .quo_nxt (quo_nxt)
    );

    // Control FSM and datapath registers; flush overrides everything but reset
    always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
        if (!s_resetn_i) begin
            state  <= DS_IDLE;
            cnt    <= '0;
            func_q <= DIVF_DIV;
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            sign_q <= 1'b0;
            sign_r <= 1'b0;
            dz_q   <= 1'b0;
        end else if (s_flush_i) begin
            state <= DS_IDLE;
        end else begin
            case (state)
                DS_IDLE: begin
                    if (s_start_i) begin
                        func_q <= div_func'(s_func_i);
                        dvs_q  <= op2_abs;
                        sign_q <= s_op1_i[XLEN-1] ^ s_op2_i[XLEN-1];
                        sign_r <= s_op1_i[XLEN-1];
                        dz_q   <= dz_in;
                        cnt    <= CNT_W'(XLEN - 1);
                        if (early) begin
                            // Preload exactly what the full iteration would have produced
                            quo_q <= dz_in ? '1 : {1'b1, {(XLEN-1){1'b0}}};
                            rem_q <= dz_in ? op1_abs : '0;
                            state <= DS_DONE;
                        end else begin
                            quo_q <= op1_abs;
                            rem_q <= '0;
                            state <= DS_BUSY;
                        end
                    end
                end
                DS_BUSY: begin
                    rem_q <= rem_nxt;
                    quo_q <= quo_nxt;
                    if (cnt == '0) begin
                        state <= DS_DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DS_DONE: begin
                    if (!s_hold_i) begin
                        state <= DS_IDLE;
                    end
                end
                default: state <= DS_IDLE;
            endcase
        end
    end

    // Sign correction; a zero divisor keeps the all-ones quotient untouched
    always_comb begin
        res = '0;
        if (is_rem_f(func_q)) begin
            res = (is_signed_f(func_q) && sign_r) ? -rem_q : rem_q;
        end else begin
            res = (is_signed_f(func_q) && sign_q && !dz_q) ? -quo_q : quo_q;
        end
    end

    assign s_busy_o   = accept || (state == DS_BUSY);
    assign s_done_o   = (state == DS_DONE) && !s_flush_i;
    assign s_result_o = s_done_o ? res : '0;

endmodule
